reg_file_debug_port: RTL and testbench
======================================

// Module: reg_file_debug_port
// PURPOSE
//  Initiator/arbiter on the register-file port set (wr_en, wr_reg, wr_data, rd_reg_1/2 -> rd_data_1/2).
//  Sits between the core datapath and the register file. After reset it sweeps x1..x31 to zero,
//  then passes core accesses through. It also serves single-word debug reads/writes over a
//  valid/ready request/response handshake while the core is halted.
//  The register file reads combinationally, writes on posedge clk, and hardwires x0 to 0.
// PARAMETERS
//  NUM_REGS        32  register count; ADDR_WIDTH = $clog2(NUM_REGS)
//  DATA_WIDTH      32  register width
//  CLEAR_ON_RESET  1   1: run CLEAR sweep after reset; 0: reset goes straight to IDLE
// PORTS
//  clk             in   1   clock; all state on posedge
//  rst             in   1   reset; synchronous, active-high
//  core_wr_en      in   1   core write enable
//  core_wr_reg     in   5   core write address
//  core_wr_data    in   32  core write data
//  core_rd_reg_1   in   5   core read address 1
//  core_rd_reg_2   in   5   core read address 2
//  core_rd_data_1  out  32  = rf_rd_data_1, combinational pass-through
//  core_rd_data_2  out  32  = rf_rd_data_2, combinational pass-through
//  core_halted     in   1   core is halted; debug requests are accepted only when this is 1
//  core_stall      out  1   1 in every state except IDLE
//  init_done       out  1   1 once the CLEAR sweep has completed
//  dbg_req_valid   in   1   debug request valid
//  dbg_req_ready   out  1   debug request ready
//  dbg_req_write   in   1   1 = write, 0 = read
//  dbg_req_addr    in   5   target register
//  dbg_req_wdata   in   32  write data
//  dbg_resp_valid  out  1   response valid
//  dbg_resp_ready  in   1   response accepted
//  dbg_resp_rdata  out  32  read data; 0 for writes
//  rf_wr_en        out  1   to register file
//  rf_wr_reg       out  5   to register file
//  rf_wr_data      out  32  to register file
//  rf_rd_reg_1     out  5   to register file
//  rf_rd_reg_2     out  5   to register file
//  rf_rd_data_1    in   32  from register file
//  rf_rd_data_2    in   32  from register file
// BEHAVIOUR
//  FSM states: CLEAR, IDLE, ACCESS, RESP. rst=1 in any state: next state CLEAR (IDLE if
//   CLEAR_ON_RESET=0). rst also sets idx=1, clears dbg_resp_valid and dbg_resp_rdata,
//   and drops any captured request.
//  Reset values: core_stall=1, init_done=0, dbg_req_ready=0, dbg_resp_valid=0,
//   dbg_resp_rdata=0, rf_wr_en=1, rf_wr_reg=1, rf_wr_data=0. rf_rd_reg_1/2 follow the core.
//  CLEAR: drives rf_wr_en=1, rf_wr_reg=idx, rf_wr_data=0; idx increments each cycle.
//   At idx==NUM_REGS-1 the next state is IDLE: 31 write cycles, then init_done=1 and it
//   stays 1 until rst. Core inputs are ignored; dbg_req_ready=0.
//  IDLE: all rf_* outputs = the matching core_* inputs. dbg_req_ready = core_halted.
//   On dbg_req_valid & dbg_req_ready: capture write/addr/wdata, next state ACCESS.
//  ACCESS (exactly 1 cycle): core_wr_en is masked. rf_rd_reg_1 = captured addr.
//   Write: rf_wr_en = (addr != 0), rf_wr_reg = addr, rf_wr_data = wdata, and rdata is latched as 0.
//   Read: rf_wr_en=0, and rdata is latched from rf_rd_data_1 at the clock edge.
//   Next state RESP.
//  RESP: dbg_resp_valid=1; rdata is held stable until dbg_resp_ready. Ready seen at a clock
//   edge: next state IDLE, and dbg_resp_valid goes 0 that edge.
//  Once accepted, a transaction always completes, even if core_halted drops in ACCESS or RESP.
//  Request-to-response latency: accept edge -> dbg_resp_valid high 2 edges later.
//  Back-to-back requests: new requests are accepted only from IDLE, so the minimum
//   spacing is 3 cycles.
// TESTING
//  1 rst 1 cycle -> rf_wr_en=1 with rf_wr_reg=1..31 and data 0 for 31 cycles; then init_done=1,
//    core_stall=0; every register reads 0.
//  2 core writes x5=0xDEADBEEF -> next cycle core_rd_reg_1=5 gives core_rd_data_1=0xDEADBEEF.
//  3 dbg write x7=0x12345678 with core_halted=0 -> dbg_req_ready=0 and nothing happens;
//    raise halted -> accepted, resp_valid 2 edges later with rdata=0; core reads x7=0x12345678.
//  4 dbg read x7 with dbg_resp_ready low 5 cycles -> resp_valid=1 and rdata=0x12345678 stable
//    throughout; raise ready -> IDLE next edge, core_stall=0.
//  5 dbg write x0=0xFFFFFFFF -> rf_wr_en stays 0 in ACCESS; a dbg read of x0 returns 0.
//  6 rst during RESP -> dbg_resp_valid=0 next edge, CLEAR restarts; after init_done x7 reads 0.

Source files
------------

// File: rtl/reg_file_debug_port_if.sv
// Debug request/response channel for the register-file debug port.
// The master side (debugger) issues single-word requests; the slave side answers each one.
interface reg_file_debug_port_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/reg_file_debug_port.sv
// Register-file port arbiter: zero-sweeps x1..x(N-1) after reset, then passes core accesses
// through and serves single-word debug reads/writes while the core is halted.
module reg_file_debug_port #(
    parameter int  NUM_REGS       = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int ADDR_WIDTH     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_wr_en,
    input  logic [ADDR_WIDTH-1:0] core_wr_reg,
    input  logic [DATA_WIDTH-1:0] core_wr_data,
    input  logic [ADDR_WIDTH-1:0] core_rd_reg_1,
    input  logic [ADDR_WIDTH-1:0] core_rd_reg_2,
    output logic [DATA_WIDTH-1:0] core_rd_data_1,
    output logic [DATA_WIDTH-1:0] core_rd_data_2,
    input  logic                  core_halted,
    output logic                  core_stall,
    output logic                  init_done,

    reg_file_debug_port_if.slave  dbg,

    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_reg,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic [ADDR_WIDTH-1:0] rf_rd_reg_1,
    output logic [ADDR_WIDTH-1:0] rf_rd_reg_2,
    input  logic [DATA_WIDTH-1:0] rf_rd_data_1,
    input  logic [DATA_WIDTH-1:0] rf_rd_data_2
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam state_t                RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  req_ready;
    logic                  req_fire;

    assign core_rd_data_1  = rf_rd_data_1;
    assign core_rd_data_2  = rf_rd_data_2;
    assign req_fire        = dbg.req_valid && req_ready;
    assign dbg.req_ready   = req_ready;
    assign dbg.resp_valid  = (state == RESP);
    assign dbg.resp_rdata  = resp_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            idx        <= ADDR_WIDTH'(1);
            init_done  <= 1'b0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                idx <= idx + ADDR_WIDTH'(1);
            end
            // Without a sweep the file is considered ready as soon as reset is released.
            if ((state == CLEAR && idx == LAST_IDX) || !CLEAR_ON_RESET) begin
                init_done <= 1'b1;
            end
            if (state == IDLE && req_fire) begin
                cap_write <= dbg.req_write;
                cap_addr  <= dbg.req_addr;
                cap_wdata <= dbg.req_wdata;
            end
            if (state == ACCESS) begin
                resp_rdata <= cap_write ? '0 : rf_rd_data_1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next  = state;
        core_stall  = (state != IDLE);
        req_ready   = 1'b0;
        rf_wr_en    = core_wr_en;
        rf_wr_reg   = core_wr_reg;
        rf_wr_data  = core_wr_data;
        rf_rd_reg_1 = core_rd_reg_1;
        rf_rd_reg_2 = core_rd_reg_2;

        unique case (state)
            CLEAR: begin
                rf_wr_en   = 1'b1;
                rf_wr_reg  = idx;
                rf_wr_data = '0;
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                req_ready = core_halted;
                if (req_fire) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // x0 is hardwired, so a debug write to it never reaches the file.
                rf_wr_en    = cap_write && (cap_addr != '0);
                rf_wr_reg   = cap_addr;
                rf_wr_data  = cap_wdata;
                rf_rd_reg_1 = cap_addr;
                state_next  = RESP;
            end
            RESP: begin
                rf_wr_en = 1'b0;
                if (dbg.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_file_debug_port.sv
// Self-checking bench for reg_file_debug_port: behavioural register file, shadow model
// of register contents, and a queue of expected debug read data.
module tb_reg_file_debug_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wr_en;
    logic [4:0]  core_wr_reg;
    logic [31:0] core_wr_data;
    logic [4:0]  core_rd_reg_1;
    logic [4:0]  core_rd_reg_2;
    logic [31:0] core_rd_data_1;
    logic [31:0] core_rd_data_2;
    logic        core_halted;
    logic        core_stall;
    logic        init_done;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_reg;
    logic [31:0] rf_wr_data;
    logic [4:0]  rf_rd_reg_1;
    logic [4:0]  rf_rd_reg_2;
    logic [31:0] rf_rd_data_1;
    logic [31:0] rf_rd_data_2;

    reg_file_debug_port_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dbg ();

    reg_file_debug_port #(
        .NUM_REGS(32), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .core_wr_en(core_wr_en), .core_wr_reg(core_wr_reg), .core_wr_data(core_wr_data),
        .core_rd_reg_1(core_rd_reg_1), .core_rd_reg_2(core_rd_reg_2),
        .core_rd_data_1(core_rd_data_1), .core_rd_data_2(core_rd_data_2),
        .core_halted(core_halted), .core_stall(core_stall), .init_done(init_done),
        .dbg(dbg),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
        .rf_rd_reg_1(rf_rd_reg_1), .rf_rd_reg_2(rf_rd_reg_2),
        .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, posedge write, x0 hardwired to 0.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_wr_en && rf_wr_reg != 5'd0) rf_mem[rf_wr_reg] <= rf_wr_data;
    end
    assign rf_rd_data_1 = (rf_rd_reg_1 == 5'd0) ? 32'd0 : rf_mem[rf_rd_reg_1];
    assign rf_rd_data_2 = (rf_rd_reg_2 == 5'd0) ? 32'd0 : rf_mem[rf_rd_reg_2];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_accept = 0;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        core_wr_en = 1'b1; core_wr_reg = 5'd3; core_wr_data = 32'hAAAA_5555;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (core_stall !== 1'b1 || init_done !== 1'b0 || dbg.req_ready !== 1'b0 ||
            dbg.resp_valid !== 1'b0 || dbg.resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: stall=%b init=%b rdy=%b rv=%b rdata=%h required 1 0 0 0 0",
                     core_stall, init_done, dbg.req_ready, dbg.resp_valid, dbg.resp_rdata);
        end
        for (int i = 1; i <= 31; i++) begin
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_reg !== 5'(i) || rf_wr_data !== 32'd0 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL clear_sweep[%0d]: en=%b reg=%0d data=%h init=%b required 1 %0d 0 0",
                         i, rf_wr_en, rf_wr_reg, rf_wr_data, init_done, i);
            end
            tick();
            #1;
        end
        core_wr_en = 1'b0;
        #1;
        checks++;
        if (init_done !== 1'b1 || core_stall !== 1'b0) begin
            failures++;
            $display("FAIL clear_done: init=%b stall=%b required 1 0", init_done, core_stall);
        end
        for (int r = 0; r < 32; r++) begin
            model[r] = 32'd0;
            core_rd_reg_1 = 5'(r);
            core_rd_reg_2 = 5'(31 - r);
            #1;
            checks++;
            if (core_rd_data_1 !== 32'd0 || core_rd_data_2 !== 32'd0) begin
                failures++;
                $display("FAIL zero_after_clear x%0d/x%0d: got %h/%h required 0", r, 31 - r,
                         core_rd_data_1, core_rd_data_2);
            end
        end
    endtask

    task automatic test_core_write();
        tick();
        core_wr_en = 1'b1; core_wr_reg = 5'd5; core_wr_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 5'd5 || rf_wr_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL core_write_pass: en=%b reg=%0d data=%h required 1 5 deadbeef",
                     rf_wr_en, rf_wr_reg, rf_wr_data);
        end
        tick();
        model[5] = 32'hDEAD_BEEF;
        core_wr_en = 1'b0; core_rd_reg_1 = 5'd5; core_rd_reg_2 = 5'd5;
        #1;
        checks++;
        if (rf_rd_reg_1 !== 5'd5 || core_rd_data_1 !== model[5] || core_rd_data_2 !== model[5]) begin
            failures++;
            $display("FAIL core_read_x5: reg=%0d d1=%h d2=%h required 5 %h", rf_rd_reg_1,
                     core_rd_data_1, core_rd_data_2, model[5]);
        end
    endtask

    // Drives one request, waits (bounded) for acceptance, checks ACCESS, and returns in RESP.
    task automatic dbg_issue(input bit write, input logic [4:0] addr, input logic [31:0] wdata,
                             input bit drop_halt);
        int          waited = 0;
        logic [31:0] exp;
        dbg.req_valid = 1'b1; dbg.req_write = write; dbg.req_addr = addr; dbg.req_wdata = wdata;
        #1;
        while (dbg.req_ready !== 1'b1 && waited < 20) begin
            tick();
            #1;
            waited++;
        end
        checks++;
        if (dbg.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL dbg_accept_timeout: req_ready=%b after %0d cycles required 1", dbg.req_ready, waited);
            dbg.req_valid = 1'b0;
            return;
        end
        exp = (write || addr == 5'd0) ? 32'd0 : model[addr];
        exp_q.push_back(exp);
        if (write && addr != 5'd0) model[addr] = wdata;
        last_accept = cyc;
        tick();
        dbg.req_valid = 1'b0;
        if (drop_halt) core_halted = 1'b0;
        #1;
        checks++;
        if (rf_wr_en !== (write && addr != 5'd0) || core_stall !== 1'b1 ||
            dbg.resp_valid !== 1'b0 || dbg.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL access_ctrl x%0d: wr_en=%b stall=%b rv=%b rdy=%b required %b 1 0 0",
                     addr, rf_wr_en, core_stall, dbg.resp_valid, dbg.req_ready, write && addr != 5'd0);
        end
        checks++;
        if (write && addr != 5'd0 && (rf_wr_reg !== addr || rf_wr_data !== wdata)) begin
            failures++;
            $display("FAIL access_write x%0d: reg=%0d data=%h required %0d %h", addr, rf_wr_reg,
                     rf_wr_data, addr, wdata);
        end else if (!write && rf_rd_reg_1 !== addr) begin
            failures++;
            $display("FAIL access_read_addr: rf_rd_reg_1=%0d required %0d", rf_rd_reg_1, addr);
        end
        tick();
        checks++;
        if (dbg.resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL resp_latency: resp_valid=%b two edges after accept required 1", dbg.resp_valid);
        end
    endtask

    // Holds resp_ready low for 'hold' cycles, then completes the response against the scoreboard.
    task automatic dbg_collect(input int hold);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected response queued");
            exp = 32'd0;
        end else begin
            exp = exp_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (dbg.resp_valid !== 1'b1 || dbg.resp_rdata !== exp || core_stall !== 1'b1) begin
                failures++;
                $display("FAIL resp_hold[%0d]: rv=%b rdata=%h stall=%b required 1 %h 1", i,
                         dbg.resp_valid, dbg.resp_rdata, core_stall, exp);
            end
            tick();
        end
        dbg.resp_ready = 1'b1;
        #1;
        checks++;
        if (dbg.resp_valid !== 1'b1 || dbg.resp_rdata !== exp) begin
            failures++;
            $display("FAIL resp_data: rv=%b rdata=%h required 1 %h", dbg.resp_valid, dbg.resp_rdata, exp);
        end
        tick();
        dbg.resp_ready = 1'b0;
        #1;
        checks++;
        if (dbg.resp_valid !== 1'b0 || core_stall !== 1'b0) begin
            failures++;
            $display("FAIL resp_release: rv=%b stall=%b required 0 0", dbg.resp_valid, core_stall);
        end
    endtask

    task automatic test_dbg_gated_write();
        tick();
        core_halted = 1'b0;
        dbg.req_valid = 1'b1; dbg.req_write = 1'b1; dbg.req_addr = 5'd7; dbg.req_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dbg.req_ready !== 1'b0 || core_stall !== 1'b0 || dbg.resp_valid !== 1'b0 || rf_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL not_halted[%0d]: rdy=%b stall=%b rv=%b wr_en=%b required 0 0 0 0", i,
                         dbg.req_ready, core_stall, dbg.resp_valid, rf_wr_en);
            end
            tick();
        end
        core_halted = 1'b1;
        dbg_issue(1'b1, 5'd7, 32'h1234_5678, 1'b0);
        dbg_collect(0);
        core_halted = 1'b0;
        core_rd_reg_1 = 5'd7;
        #1;
        checks++;
        if (core_rd_data_1 !== 32'h1234_5678) begin
            failures++;
            $display("FAIL core_read_x7: got %h required 12345678", core_rd_data_1);
        end
    endtask

    task automatic test_dbg_read_hold();
        core_halted = 1'b1;
        dbg_issue(1'b0, 5'd7, 32'hFFFF_FFFF, 1'b0);
        dbg_collect(5);
    endtask

    task automatic test_x0();
        dbg_issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        dbg_collect(0);
        dbg_issue(1'b0, 5'd0, 32'd0, 1'b0);
        dbg_collect(1);
    endtask

    task automatic test_halt_drop();
        core_halted = 1'b1;
        core_wr_en = 1'b1; core_wr_reg = 5'd9; core_wr_data = 32'h0BAD_F00D;
        model[9] = 32'h0BAD_F00D;
        dbg_issue(1'b0, 5'd9, 32'd0, 1'b1);
        core_wr_en = 1'b0;
        dbg_collect(2);
    endtask

    task automatic test_back_to_back();
        int first;
        core_halted = 1'b1;
        dbg_issue(1'b1, 5'd10, 32'hA5A5_5A5A, 1'b0);
        first = last_accept;
        dbg_collect(0);
        dbg_issue(1'b0, 5'd10, 32'd0, 1'b0);
        checks++;
        if (last_accept - first !== 3) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles required 3", last_accept - first);
        end
        dbg_collect(0);
    endtask

    task automatic test_reset_in_resp();
        int waited = 0;
        dbg_issue(1'b0, 5'd7, 32'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 32; r++) model[r] = 32'd0;
        #1;
        checks++;
        if (dbg.resp_valid !== 1'b0 || dbg.resp_rdata !== 32'd0 || rf_wr_en !== 1'b1 ||
            rf_wr_reg !== 5'd1 || core_stall !== 1'b1 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_resp: rv=%b rdata=%h en=%b reg=%0d stall=%b init=%b required 0 0 1 1 1 0",
                     dbg.resp_valid, dbg.resp_rdata, rf_wr_en, rf_wr_reg, core_stall, init_done);
        end
        while (init_done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL reclear_timeout: init_done=%b after %0d cycles required 1", init_done, waited);
        end
        core_halted = 1'b0;
        core_rd_reg_1 = 5'd7;
        #1;
        checks++;
        if (core_rd_data_1 !== model[7]) begin
            failures++;
            $display("FAIL x7_after_reclear: got %h required %h", core_rd_data_1, model[7]);
        end
    endtask

    initial begin
        rst = 1'b0;
        core_wr_en = 1'b0; core_wr_reg = 5'd0; core_wr_data = 32'd0;
        core_rd_reg_1 = 5'd0; core_rd_reg_2 = 5'd0; core_halted = 1'b0;
        dbg.req_valid = 1'b0; dbg.req_write = 1'b0; dbg.req_addr = 5'd0; dbg.req_wdata = 32'd0;
        dbg.resp_ready = 1'b0;
        tick();
        test_reset();
        test_core_write();
        test_dbg_gated_write();
        test_dbg_read_hold();
        test_x0();
        test_halt_drop();
        test_back_to_back();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
